mp_node: RTL and testbench
==========================

MP_NODE -- requirements
Module: mp_node

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NODE_NUMBER, 0, this node's address.
- NODE_COUNT, 8, number of nodes on the interposer.
- ID_W, 3, address width.
- PAYLOAD_W, 16, payload width.
- MSG_W, PAYLOAD_W+2*ID_W, message width; format {dst, src, payload}.
- FIFO_DEPTH, 4, per-direction TX queue depth; power of 2, at least 2.
- INJ_RATE, 4, injection threshold, 0..16.
- LFSR_SEED, 16'hACE1, generator seed; must be nonzero.
- CNT_W, 16, statistics counter width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-low; clock clk.
- gen_en, in, 1, enables traffic generation.
- msg_in, in, 2*MSG_W, incoming lanes {dir1, dir0}.
- valid_in, in, 2, per-lane valid.
- grant, in, 2, arbiter grant per direction.
- req, out, 2, arbiter request per direction.
- req_dst, out, 2*ID_W, head-of-queue destination per direction.
- msg_out, out, 2*MSG_W, outgoing lanes.
- valid_out, out, 2, outgoing valid.
- rx_valid, out, 2, received-message strobe per lane.
- rx_msg, out, 2*MSG_W, received message per lane.
- tx_count, out, CNT_W, messages sent.
- rx_count, out, CNT_W, messages accepted.
- drop_count, out, CNT_W, generated messages dropped.

Function
REQ-003 Direction 1 carries traffic to higher addresses (dst > NODE_NUMBER); direction 0 carries traffic to lower addresses.
REQ-004 Generator: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advances every cycle while gen_en=1.
REQ-005 Injection occurs on a cycle when gen_en=1 and lfsr[3:0] < INJ_RATE.
- dst = lfsr[15:16-ID_W] mod NODE_COUNT.
- If dst==NODE_NUMBER, dst becomes (NODE_NUMBER+1) mod NODE_COUNT.
- src = NODE_NUMBER; payload = lfsr[PAYLOAD_W-1:0].
REQ-006 An injected message is pushed into its direction's FIFO; if that FIFO is full, the message is dropped and drop_count increments.
REQ-007 Each direction runs its own FSM:
- IDLE -> REQ when the FIFO is non-empty.
- REQ: req=1 and req_dst = head dst; grant=1 -> SEND.
- SEND: valid_out=1 and msg_out = head for exactly one cycle; FIFO pops; tx_count increments; -> REQ if still non-empty, else IDLE.
REQ-008 Latency from grant sample to valid_out is 1 cycle; req deasserts in SEND; grant in IDLE or SEND is ignored.
REQ-009 A push and a pop on the same FIFO in the same cycle are both performed and occupancy is unchanged; a push to a full FIFO is dropped even when a pop occurs that cycle.
REQ-010 Receive: valid_in[i]=1 with dst==NODE_NUMBER gives rx_valid[i]=1 and rx_msg[i]=msg_in[i] one cycle later; other dst values are ignored.
REQ-011 rx_count increments by the number of lanes accepted that cycle (0, 1 or 2).
REQ-012 All counters saturate at all-ones.
REQ-013 With NODE_NUMBER=0, direction 0 is never injected into; with NODE_NUMBER=NODE_COUNT-1, direction 1 is never injected into.
REQ-014 All outputs are registered.

Reset
REQ-015 reset=0 at a clock edge:
- LFSR loads LFSR_SEED.
- FIFOs empty.
- FSMs return to IDLE.
- All outputs and counters clear to 0.
REQ-016 Reset mid-SEND discards the queued message; valid_out is 0 on the cycle after the reset edge.

Structure
REQ-017 Message field offsets, FSM state encoding and the LFSR tap constant belong in shared package mp_pkg.
REQ-018 The per-direction queue is one sub-module, mp_fifo, instantiated twice; everything else lives in mp_node.

Verification
REQ-019 Directed scenarios, with NODE_NUMBER=3, NODE_COUNT=8:
- Reset: hold reset=0 for 2 cycles -> all outputs 0 and req=2'b00.
- Handshake: force one dst=5 message with grant held 0 -> req[1]=1, req_dst[ID_W*2-1:ID_W]=5; raise grant[1] -> valid_out[1]=1 for exactly 1 cycle on the next cycle, tx_count=1.
- Overflow: INJ_RATE=16 with grant tied 0 -> each FIFO fills to 4, after which drop_count increments on every further injection to that direction.
- Receive: valid_in=2'b11 with dst=3 on both lanes -> rx_valid=2'b11 on the next cycle, rx_count increases by 2; a lane with dst=4 -> no rx_valid.
- Self-address: LFSR state yielding dst=3 -> message queued with dst=4 on direction 1.
- Reset mid-transfer: reset=0 during SEND -> valid_out=0 on the next cycle and FIFOs empty.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared definitions for the interposer message node: message layout,
// per-direction FSM encoding and the traffic-generator LFSR.
package mp_pkg;

  localparam int NUM_DIRS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } dir_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Message layout is {dst, src, payload}
  function automatic int payload_lsb();
    return 0;
  endfunction

  function automatic int src_lsb(input int pw);
    return pw;
  endfunction

  function automatic int dst_lsb(input int id_w, input int pw);
    return pw + id_w;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mp_fifo.sv
// Per-direction TX queue. Exposes the head word plus a peek at the field of
// the entry that becomes head after a pop, so the owner can register it early.
module mp_fifo #(
  parameter int W        = 22,
  parameter int DEPTH    = 4,
  parameter int PEEK_LSB = 19,
  parameter int PEEK_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [W-1:0]      wr_dat,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              single,
  output logic [W-1:0]      head,
  output logic [PEEK_W-1:0] peek_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [AW:0]             count;
  logic                    do_push, do_pop;

  assign full       = count == (AW+1)'(DEPTH);
  assign empty      = count == '0;
  assign single     = count == (AW+1)'(1);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign head       = mem[rd_ptr];
  // With one entry left, the next head can only be the word arriving now
  assign peek_nxt   = single ? wr_dat[PEEK_LSB +: PEEK_W]
                             : mem[rd_ptr_nxt][PEEK_LSB +: PEEK_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/mp_node.sv
// Interposer message node: LFSR traffic generator, two directional TX queues
// with request/grant FSMs, two-lane receive filter and saturating statistics.
module mp_node
  import mp_pkg::*;
#(
  parameter int          NODE_NUMBER = 0,
  parameter int          NODE_COUNT  = 8,
  parameter int          ID_W        = 3,
  parameter int          PAYLOAD_W   = 16,
  parameter int          MSG_W       = PAYLOAD_W + 2*ID_W,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          INJ_RATE    = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               gen_en,
  input  logic [NUM_DIRS-1:0][MSG_W-1:0]     msg_in,
  input  logic [NUM_DIRS-1:0]                valid_in,
  input  logic [NUM_DIRS-1:0]                grant,
  output logic [NUM_DIRS-1:0]                req,
  output logic [NUM_DIRS-1:0][ID_W-1:0]      req_dst,
  output logic [NUM_DIRS-1:0][MSG_W-1:0]     msg_out,
  output logic [NUM_DIRS-1:0]                valid_out,
  output logic [NUM_DIRS-1:0]                rx_valid,
  output logic [NUM_DIRS-1:0][MSG_W-1:0]     rx_msg,
  output logic [CNT_W-1:0]                   tx_count,
  output logic [CNT_W-1:0]                   rx_count,
  output logic [CNT_W-1:0]                   drop_count
);
  localparam int            DST_LSB = dst_lsb(ID_W, PAYLOAD_W);
  localparam logic [ID_W-1:0] NODE_ID = ID_W'(NODE_NUMBER);
  localparam logic [ID_W-1:0] NEXT_ID = ID_W'((NODE_NUMBER + 1) % NODE_COUNT);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [15:0]                       lfsr;
  logic                              inject, gen_dir1, drop;
  logic [ID_W-1:0]                   gen_dst_raw, gen_dst;
  logic [MSG_W-1:0]                  gen_msg;
  logic [NUM_DIRS-1:0]               push, pop, fifo_full, fifo_empty, enter_send, rx_acc;
  logic [NUM_DIRS-1:0][MSG_W-1:0]    head;
  logic [1:0]                        tx_inc, rx_inc;

  always_ff @(posedge clk) begin
    if (!reset)      lfsr <= LFSR_SEED;
    else if (gen_en) lfsr <= lfsr_next(lfsr);
  end

  assign inject      = gen_en && ({1'b0, lfsr[3:0]} < 5'(INJ_RATE));
  assign gen_dst_raw = ID_W'(32'(lfsr[15 -: ID_W]) % 32'(NODE_COUNT));
  assign gen_dst     = (gen_dst_raw == NODE_ID) ? NEXT_ID : gen_dst_raw;
  assign gen_msg     = {gen_dst, NODE_ID, PAYLOAD_W'(lfsr)};
  assign gen_dir1    = gen_dst > NODE_ID;
  assign push        = {inject && gen_dir1, inject && !gen_dir1};
  assign drop        = inject && (gen_dir1 ? fifo_full[1] : fifo_full[0]);

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    dir_state_e      state, state_n;
    logic            fifo_single, req_d, req_q, vld_d, vld_q, rx_v_q;
    logic [ID_W-1:0] nxt_dst, dst_d, dst_q;
    logic [MSG_W-1:0] msg_d, msg_q, rx_m_q;

    mp_fifo #(
      .W(MSG_W), .DEPTH(FIFO_DEPTH), .PEEK_LSB(DST_LSB), .PEEK_W(ID_W)
    ) u_fifo (
      .clk(clk), .reset(reset), .push(push[d]), .wr_dat(gen_msg), .pop(pop[d]),
      .full(fifo_full[d]), .empty(fifo_empty[d]), .single(fifo_single),
      .head(head[d]), .peek_nxt(nxt_dst)
    );

    assign pop[d]        = state == ST_SEND;
    assign enter_send[d] = state_n == ST_SEND;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state <= ST_IDLE;
        req_q <= 1'b0;
        dst_q <= '0;
        vld_q <= 1'b0;
        msg_q <= '0;
      end else begin
        state <= state_n;
        req_q <= req_d;
        dst_q <= dst_d;
        vld_q <= vld_d;
        msg_q <= msg_d;
      end
    end

    always_comb begin
      state_n = state;
      case (state)
        ST_IDLE: if (!fifo_empty[d]) state_n = ST_REQ;
        ST_REQ:  if (grant[d])       state_n = ST_SEND;
        ST_SEND: state_n = (!fifo_single || push[d]) ? ST_REQ : ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state; leaving SEND the head is
    // being popped, so the destination comes from the following entry.
    always_comb begin
      req_d = 1'b0;
      dst_d = '0;
      vld_d = 1'b0;
      msg_d = '0;
      case (state_n)
        ST_REQ: begin
          req_d = 1'b1;
          dst_d = (state == ST_SEND) ? nxt_dst : head[d][DST_LSB +: ID_W];
        end
        ST_SEND: begin
          vld_d = 1'b1;
          msg_d = head[d];
        end
        default: ;
      endcase
    end

    assign rx_acc[d] = valid_in[d] && (msg_in[d][DST_LSB +: ID_W] == NODE_ID);

    always_ff @(posedge clk) begin
      if (!reset) begin
        rx_v_q <= 1'b0;
        rx_m_q <= '0;
      end else begin
        rx_v_q <= rx_acc[d];
        rx_m_q <= rx_acc[d] ? msg_in[d] : '0;
      end
    end

    assign req[d]       = req_q;
    assign req_dst[d]   = dst_q;
    assign valid_out[d] = vld_q;
    assign msg_out[d]   = msg_q;
    assign rx_valid[d]  = rx_v_q;
    assign rx_msg[d]    = rx_m_q;
  end

  assign tx_inc = {1'b0, enter_send[0]} + {1'b0, enter_send[1]};
  assign rx_inc = {1'b0, rx_acc[0]} + {1'b0, rx_acc[1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_count   <= '0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      tx_count   <= sat_add(tx_count, tx_inc);
      rx_count   <= sat_add(rx_count, rx_inc);
      drop_count <= sat_add(drop_count, {1'b0, drop});
    end
  end

endmodule

// File: tb/tb_mp_node.sv
// Directed bench for mp_node: node 3 at full injection rate drives the
// handshake, overflow and reset scenarios; node 0 at rate 4 checks threshold.
module tb_mp_node;
  localparam int ID_W = 3, PW = 16, MSG_W = 22, CNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                        gen_en = 1'b0;
  logic [1:0][MSG_W-1:0]       msg_in = '0;
  logic [1:0]                  valid_in = '0, grant = '0;
  logic [1:0]                  req, valid_out, rx_valid;
  logic [1:0][ID_W-1:0]        req_dst;
  logic [1:0][MSG_W-1:0]       msg_out, rx_msg;
  logic [CNT_W-1:0]            tx_count, rx_count, drop_count;

  logic                        gen_en0 = 1'b0;
  logic [1:0][MSG_W-1:0]       msg_in0 = '0;
  logic [1:0]                  valid_in0 = '0, grant0 = '0;
  logic [1:0]                  req0, valid_out0, rx_valid0;
  logic [1:0][ID_W-1:0]        req_dst0;
  logic [1:0][MSG_W-1:0]       msg_out0, rx_msg0;
  logic [CNT_W-1:0]            tx_count0, rx_count0, drop_count0;

  int total = 0, bad = 0;

  mp_node #(.NODE_NUMBER(3), .NODE_COUNT(8), .INJ_RATE(16)) dut (
    .clk(clk), .reset(reset), .gen_en(gen_en), .msg_in(msg_in), .valid_in(valid_in),
    .grant(grant), .req(req), .req_dst(req_dst), .msg_out(msg_out), .valid_out(valid_out),
    .rx_valid(rx_valid), .rx_msg(rx_msg), .tx_count(tx_count), .rx_count(rx_count),
    .drop_count(drop_count)
  );

  mp_node #(.NODE_NUMBER(0), .NODE_COUNT(8), .INJ_RATE(4)) dut0 (
    .clk(clk), .reset(reset), .gen_en(gen_en0), .msg_in(msg_in0), .valid_in(valid_in0),
    .grant(grant0), .req(req0), .req_dst(req_dst0), .msg_out(msg_out0), .valid_out(valid_out0),
    .rx_valid(rx_valid0), .rx_msg(rx_msg0), .tx_count(tx_count0), .rx_count(rx_count0),
    .drop_count(drop_count0)
  );

  function automatic logic [MSG_W-1:0] mk(input logic [2:0] d, input logic [2:0] s,
                                          input logic [15:0] p);
    return {d, s, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++; if ({req, req_dst, valid_out, msg_out, rx_valid, rx_msg} !== '0) begin bad++;
      $display("FAIL reset_outs: got %h want 0", {req, req_dst, valid_out, msg_out, rx_valid, rx_msg}); end
    total++; if ({tx_count, rx_count, drop_count} !== '0) begin bad++;
      $display("FAIL reset_cnts: got %h want 0", {tx_count, rx_count, drop_count}); end
    total++; if ({req0, valid_out0, drop_count0} !== '0) begin bad++;
      $display("FAIL reset_node0: got %h want 0", {req0, valid_out0, drop_count0}); end
    reset = 1'b1;
  endtask

  // Seed 0xACE1 -> dst 5, direction 1
  task automatic test_handshake();
    gen_en = 1'b1; tick();
    gen_en = 1'b0; tick();
    total++; if (req !== 2'b10) begin bad++; $display("FAIL hs_req: got %b want 10", req); end
    total++; if (req_dst[1] !== 3'd5 || req_dst[0] !== 3'd0) begin bad++;
      $display("FAIL hs_req_dst: got %h want 28", req_dst); end
    total++; if (valid_out !== 2'b00) begin bad++; $display("FAIL hs_early_valid: got %b want 00", valid_out); end
    grant = 2'b10; tick();
    total++; if (valid_out !== 2'b10) begin bad++; $display("FAIL hs_valid: got %b want 10", valid_out); end
    total++; if (msg_out[1] !== mk(3'd5, 3'd3, 16'hACE1)) begin bad++;
      $display("FAIL hs_msg: got %h want %h", msg_out[1], mk(3'd5, 3'd3, 16'hACE1)); end
    total++; if (tx_count !== 16'd1) begin bad++; $display("FAIL hs_tx: got %0d want 1", tx_count); end
    total++; if (req !== 2'b00) begin bad++; $display("FAIL hs_req_in_send: got %b want 00", req); end
    tick();
    total++; if (valid_out !== 2'b00 || req !== 2'b00) begin bad++;
      $display("FAIL hs_one_cycle: got valid=%b req=%b want 00 00", valid_out, req); end
    tick();
    total++; if (valid_out !== 2'b00 || tx_count !== 16'd1) begin bad++;
      $display("FAIL hs_idle_grant: got valid=%b tx=%0d want 00 1", valid_out, tx_count); end
    grant = 2'b00;
  endtask

  // 0xE270 -> dst 7, then 0x7138 -> dst 3 remapped to 4; both on direction 1
  task automatic test_self_address();
    gen_en = 1'b1; tick(); tick();
    gen_en = 1'b0;
    total++; if (req !== 2'b10 || req_dst[1] !== 3'd7) begin bad++;
      $display("FAIL sa_req1: got req=%b dst=%0d want 10 7", req, req_dst[1]); end
    grant = 2'b10; tick();
    total++; if (valid_out !== 2'b10 || msg_out[1] !== mk(3'd7, 3'd3, 16'hE270)) begin bad++;
      $display("FAIL sa_msg1: got %b %h want 10 %h", valid_out, msg_out[1], mk(3'd7, 3'd3, 16'hE270)); end
    grant = 2'b00; tick();
    total++; if (req !== 2'b10 || req_dst[1] !== 3'd4 || valid_out !== 2'b00) begin bad++;
      $display("FAIL sa_req2: got req=%b dst=%0d valid=%b want 10 4 00", req, req_dst[1], valid_out); end
    grant = 2'b10; tick();
    total++; if (msg_out[1] !== mk(3'd4, 3'd3, 16'h7138) || tx_count !== 16'd3) begin bad++;
      $display("FAIL sa_msg2: got %h tx=%0d want %h 3", msg_out[1], tx_count, mk(3'd4, 3'd3, 16'h7138)); end
    grant = 2'b00; tick();
    total++; if (req !== 2'b00 || valid_out !== 2'b00) begin bad++;
      $display("FAIL sa_idle: got req=%b valid=%b want 00 00", req, valid_out); end
  endtask

  task automatic test_receive();
    msg_in[0] = mk(3'd3, 3'd1, 16'h1234);
    msg_in[1] = mk(3'd3, 3'd6, 16'hBEEF);
    valid_in = 2'b11; tick();
    total++; if (rx_valid !== 2'b11) begin bad++; $display("FAIL rx_both_valid: got %b want 11", rx_valid); end
    total++; if (rx_msg[0] !== mk(3'd3, 3'd1, 16'h1234) || rx_msg[1] !== mk(3'd3, 3'd6, 16'hBEEF)) begin bad++;
      $display("FAIL rx_both_msg: got %h want %h", rx_msg, {mk(3'd3, 3'd6, 16'hBEEF), mk(3'd3, 3'd1, 16'h1234)}); end
    total++; if (rx_count !== 16'd2) begin bad++; $display("FAIL rx_count2: got %0d want 2", rx_count); end
    msg_in[0] = mk(3'd4, 3'd1, 16'h5555); tick();
    total++; if (rx_valid !== 2'b10 || rx_count !== 16'd3) begin bad++;
      $display("FAIL rx_filter: got %b cnt=%0d want 10 3", rx_valid, rx_count); end
    valid_in = 2'b00; tick();
    total++; if (rx_valid !== 2'b00 || rx_count !== 16'd3) begin bad++;
      $display("FAIL rx_none: got %b cnt=%0d want 00 3", rx_valid, rx_count); end
    msg_in = '0;
  endtask

  // Injections 3..15 of the seed sequence, by direction (grant held 0)
  task automatic test_overflow();
    int dir_tab[13] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 1};
    int occ0 = 0, occ1 = 0, exp_drop = 0;
    gen_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (dir_tab[i] == 0) begin if (occ0 < 4) occ0++; else exp_drop++; end
      else begin if (occ1 < 4) occ1++; else exp_drop++; end
      total++; if (drop_count !== CNT_W'(exp_drop)) begin bad++;
        $display("FAIL ovf_drop_%0d: got %0d want %0d", i, drop_count, exp_drop); end
    end
    gen_en = 1'b0; tick();
    total++; if (req !== 2'b11 || req_dst[0] !== 3'd1 || req_dst[1] !== 3'd5) begin bad++;
      $display("FAIL ovf_heads: got req=%b dst=%h want 11 29", req, req_dst); end
  endtask

  task automatic test_back_to_back_reset();
    grant = 2'b11; tick();
    total++; if (valid_out !== 2'b11 || msg_out[0] !== mk(3'd1, 3'd3, 16'h389C) ||
                 msg_out[1] !== mk(3'd5, 3'd3, 16'hB313)) begin bad++;
      $display("FAIL b2b_send1: got %b %h", valid_out, msg_out); end
    total++; if (tx_count !== 16'd5) begin bad++; $display("FAIL b2b_tx1: got %0d want 5", tx_count); end
    tick();
    total++; if (valid_out !== 2'b00 || req !== 2'b11 || req_dst[0] !== 3'd0 || req_dst[1] !== 3'd7) begin bad++;
      $display("FAIL b2b_rereq: got valid=%b req=%b dst=%h want 00 11 38", valid_out, req, req_dst); end
    tick();
    total++; if (valid_out !== 2'b11 || msg_out[0] !== mk(3'd0, 3'd3, 16'h1C4E) ||
                 msg_out[1] !== mk(3'd7, 3'd3, 16'hED89) || tx_count !== 16'd7) begin bad++;
      $display("FAIL b2b_send2: got %b %h tx=%0d", valid_out, msg_out, tx_count); end
    reset = 1'b0; tick();
    total++; if (valid_out !== 2'b00 || req !== 2'b00 || tx_count !== '0 || drop_count !== '0) begin bad++;
      $display("FAIL rst_mid_send: got valid=%b req=%b tx=%0d drop=%0d want all 0",
               valid_out, req, tx_count, drop_count); end
    reset = 1'b1; grant = 2'b00; tick(); tick();
    total++; if (req !== 2'b00 || valid_out !== 2'b00) begin bad++;
      $display("FAIL rst_fifo_empty: got req=%b valid=%b want 00 00", req, valid_out); end
  endtask

  // Node 0, rate 4: injections at sequence steps 0,1,6,9,10, all to direction 1
  task automatic test_node0();
    gen_en0 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 10) begin
        total++; if (drop_count0 !== 16'd0) begin bad++; $display("FAIL n0_drop10: got %0d want 0", drop_count0); end
      end
      if (k == 11) begin
        total++; if (drop_count0 !== 16'd1) begin bad++; $display("FAIL n0_drop11: got %0d want 1", drop_count0); end
      end
    end
    gen_en0 = 1'b0; tick();
    total++; if (drop_count0 !== 16'd1) begin bad++; $display("FAIL n0_drop_end: got %0d want 1", drop_count0); end
    total++; if (req0 !== 2'b10 || req_dst0[1] !== 3'd5 || req_dst0[0] !== 3'd0) begin bad++;
      $display("FAIL n0_dir: got req=%b dst=%h want 10 28", req0, req_dst0); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_self_address();
    test_receive();
    test_overflow();
    test_back_to_back_reset();
    test_node0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
